// File: rtl/morse_encoder.sv
// Plays one Morse letter (dot/dash pattern + symbol count) as a timed on/off keying signal.
// All outputs are registered; element timing comes from a single down-counter.
//
// state | meaning
// IDLE  | waiting for a start request, ready=1
// MARK  | tone on for one dot (U) or dash (3U)
// SPACE | tone off for U between symbols of the letter
// GAP   | tone off for 3U after the last symbol, then done pulse

module morse_encoder #(
    parameter int UNIT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] pattern,
    input  logic [2:0] len,
    output logic       tone_out,
    output logic       ready,
    output logic       done
);

    localparam longint UNIT_L  = longint'(UNIT_CYCLES);
    localparam int     CW      = $clog2(UNIT_L * 3);
    // Counter holds duration-1 so an element of D cycles expires on the D-th edge.
    localparam logic [CW-1:0] LOAD_U  = CW'(UNIT_L - 1);
    localparam logic [CW-1:0] LOAD_3U = CW'(UNIT_L * 3 - 1);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    pat_q;
    logic [2:0]    len_q;

    logic [1:0]    idx_nxt;
    logic          len_ok;
    logic          more_symbols;

    always_comb begin
        idx_nxt      = idx + 2'd1;
        len_ok       = (len != 3'd0) && (len <= 3'd4);
        more_symbols = ({1'b0, idx} + 3'd1) < len_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            pat_q    <= '0;
            len_q    <= '0;
            tone_out <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && len_ok) begin
                        pat_q    <= pattern;
                        len_q    <= len;
                        idx      <= 2'd0;
                        cnt      <= pattern[0] ? LOAD_3U : LOAD_U;
                        state    <= MARK;
                        tone_out <= 1'b1;
                        ready    <= 1'b0;
                    end
                end
                MARK: begin
                    if (cnt == '0) begin
                        tone_out <= 1'b0;
                        if (more_symbols) begin
                            state <= SPACE;
                            cnt   <= LOAD_U;
                        end else begin
                            state <= GAP;
                            cnt   <= LOAD_3U;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SPACE: begin
                    if (cnt == '0) begin
                        idx      <= idx_nxt;
                        cnt      <= pat_q[idx_nxt] ? LOAD_3U : LOAD_U;
                        state    <= MARK;
                        tone_out <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tone_out <= 1'b0;
                    ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder: per-cycle expected {tone_out, ready, done} is
// queued from the letter timing rules and compared at each falling clock edge.

module tb_morse_encoder;

    localparam int U = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] pattern;
    logic [2:0] len;
    logic       tone_out;
    logic       ready;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_q[$];

    morse_encoder #(.UNIT_CYCLES(U)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .tone_out (tone_out),
        .ready    (ready),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expected waveform for cycles 1..done of one letter.
    task automatic push_letter(input logic [3:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            int dur;
            dur = pat[i] ? 3 * U : U;
            for (int c = 0; c < dur; c++) exp_q.push_back(3'b100);
            if (i < n - 1)
                for (int c = 0; c < U; c++) exp_q.push_back(3'b000);
        end
        for (int c = 0; c < 3 * U; c++) exp_q.push_back(3'b000);
        exp_q.push_back(3'b011);
    endtask

    task automatic drain(input string name);
        int cyc;
        logic [2:0] e;
        cyc = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_val($sformatf("%s c%0d", name, cyc), {29'd0, tone_out, ready, done}, {29'd0, e});
            cyc++;
        end
    endtask

    // Called before the accepting edge; returns at the falling edge of the done cycle.
    task automatic play(input string name, input logic [3:0] pat, input logic [2:0] n, input bit hold);
        pattern = pat;
        len     = n;
        start   = 1'b1;
        push_letter(pat, int'(n));
        @(posedge clk);
        #1;
        if (!hold) begin
            start   = 1'b0;
            pattern = 4'($urandom);
            len     = 3'($urandom);
        end
        drain(name);
    endtask

    task automatic idle_req(input string name, input logic [2:0] n, input int cycles);
        pattern = 4'($urandom);
        len     = n;
        start   = 1'b1;
        for (int c = 0; c < cycles; c++) exp_q.push_back(3'b010);
        drain(name);
        start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        pattern = 4'd0;
        len     = 3'd0;
        repeat (2) @(negedge clk);
        check_val("reset", {29'd0, tone_out, ready, done}, 32'b010);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        play("E", 4'b0000, 3'd1, 1'b0);
        play("A", 4'b0010, 3'd2, 1'b0);
        play("Q", 4'b1011, 3'd4, 1'b0);
        play("T", 4'b1111, 3'd1, 1'b0);
        play("A_hi", 4'b1110, 3'd2, 1'b0);
        play("M_hold", 4'b0011, 3'd2, 1'b1);
        play("M_next", 4'b0011, 3'd2, 1'b0);

        idle_req("len0", 3'd0, 6);
        idle_req("len5", 3'd5, 6);
        idle_req("len7", 3'd7, 3);

        // O, reset asserted during cycle 6 (inside the first dash)
        pattern = 4'b0111;
        len     = 3'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check_val($sformatf("O c%0d", c), {29'd0, tone_out, ready, done}, 32'b100);
        end
        #1 rst_n = 1'b0;
        #1 check_val("O async rst", {29'd0, tone_out, ready, done}, 32'b010);
        repeat (2) begin
            @(negedge clk);
            check_val("O in rst", {29'd0, tone_out, ready, done}, 32'b010);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("O post rst", {29'd0, tone_out, ready, done}, 32'b010);

        play("S", 4'b0000, 3'd3, 1'b0);
        play("K", 4'b0101, 3'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
